// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and response owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_age.sv
// Fetch starvation counter: counts lost contentions, flags fetch as urgent.
// Instantiated only when MEM_ARB_AGE_EN is defined.
module mem_arb_age #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic lose,
    input  logic clear,
    output logic urgent
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (lose && count != 4'hf) begin
            count <= count + 4'd1;
        end
    end

    assign urgent = (count >= WAIT_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the shared memory port (fetch vs data).
// Optional fetch ageing is enabled by defining MEM_ARB_AGE_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [AWIDTH-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DWIDTH-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [AWIDTH-1:0]   dm_addr,
    input  logic [DWIDTH-1:0]   dm_wdata,
    input  logic [DWIDTH/8-1:0] dm_wmask,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DWIDTH-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_wdata,
    output logic [DWIDTH/8-1:0] mem_wmask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DWIDTH-1:0]   mem_rdata,
    output logic                busy
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
        $error("MAX_WAIT must be in 1..15");
    end

    state_t state;
    owner_t sel;
    logic   drop;
    logic   idle;
    logic   urgent;

    assign idle = (state == IDLE) && !rst;

`ifdef MEM_ARB_AGE_EN
    logic lose;

    assign lose = idle && if_req && dm_req && !urgent;

    mem_arb_age #(
        .MAX_WAIT(MAX_WAIT)
    ) u_age (
        .clk   (clk),
        .rst   (rst),
        .lose  (lose),
        .clear (if_gnt),
        .urgent(urgent)
    );
`else
    assign urgent = 1'b0;
`endif

    // Data holds the older instruction, so it wins unless fetch is urgent.
    assign sel = (if_req && (!dm_req || urgent)) ? OWN_IF : OWN_DM;

    assign mem_req   = idle && (if_req || dm_req);
    assign mem_we    = (sel == OWN_DM) && dm_we;
    assign mem_addr  = (sel == OWN_DM) ? dm_addr : if_addr;
    assign mem_wdata = (sel == OWN_DM) ? dm_wdata : '0;
    assign mem_wmask = mem_we ? dm_wmask : '0;

    assign if_gnt = mem_req && mem_gnt && (sel == OWN_IF);
    assign dm_gnt = mem_req && mem_gnt && (sel == OWN_DM);

    // A kill arriving with the response itself still suppresses it.
    assign if_rvalid = (state == WAIT_I) && mem_rvalid && !drop && !if_kill;
    assign dm_rvalid = (state == WAIT_D) && mem_rvalid;
    assign if_rdata  = (state == WAIT_I) ? mem_rdata : '0;
    assign dm_rdata  = (state == WAIT_D) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            drop  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    drop <= if_gnt && if_kill;
                    if (if_gnt) begin
                        state <= WAIT_I;
                        busy  <= 1'b1;
                    end else if (dm_gnt) begin
                        state <= WAIT_D;
                        busy  <= 1'b1;
                    end
                end
                WAIT_I: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        drop  <= 1'b0;
                    end else if (if_kill) begin
                        drop <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_kill, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [3:0]    dm_wmask;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          busy;

    mem_port_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wmask(dm_wmask), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic ir; logic [31:0] ia; logic ik;
        logic dr; logic dw; logic [31:0] da; logic [31:0] dd; logic [3:0] dm;
        logic mg; logic mv; logic [31:0] md;
        logic eig; logic edg; logic emr; logic eiv; logic edv; logic eb;
        logic [31:0] eaddr; logic [3:0] emask; logic ewe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic ir, logic [31:0] ia, logic ik,
        logic dr, logic dw, logic [31:0] da, logic [31:0] dd, logic [3:0] dm,
        logic mg, logic mv, logic [31:0] md,
        logic eig, logic edg, logic emr, logic eiv, logic edv, logic eb,
        logic [31:0] eaddr, logic [3:0] emask, logic ewe);
        vec_t t;
        t.ir = ir; t.ia = ia; t.ik = ik;
        t.dr = dr; t.dw = dw; t.da = da; t.dd = dd; t.dm = dm;
        t.mg = mg; t.mv = mv; t.md = md;
        t.eig = eig; t.edg = edg; t.emr = emr; t.eiv = eiv; t.edv = edv;
        t.eb = eb; t.eaddr = eaddr; t.emask = emask; t.ewe = ewe;
        return t;
    endfunction

    task automatic drive_idle();
        if_req = 0; if_addr = 0; if_kill = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wmask = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apply_vec(vec_t t, int idx);
        if_req = t.ir; if_addr = t.ia; if_kill = t.ik;
        dm_req = t.dr; dm_we = t.dw; dm_addr = t.da;
        dm_wdata = t.dd; dm_wmask = t.dm;
        mem_gnt = t.mg; mem_rvalid = t.mv; mem_rdata = t.md;
        #4;
        chk($sformatf("v%0d if_gnt", idx), if_gnt, t.eig);
        chk($sformatf("v%0d dm_gnt", idx), dm_gnt, t.edg);
        chk($sformatf("v%0d mem_req", idx), mem_req, t.emr);
        chk($sformatf("v%0d if_rvalid", idx), if_rvalid, t.eiv);
        chk($sformatf("v%0d dm_rvalid", idx), dm_rvalid, t.edv);
        chk($sformatf("v%0d busy", idx), busy, t.eb);
        if (t.emr) begin
            chk($sformatf("v%0d mem_addr", idx), mem_addr, t.eaddr);
            chk($sformatf("v%0d mem_wmask", idx), mem_wmask, t.emask);
            chk($sformatf("v%0d mem_we", idx), mem_we, t.ewe);
            if (t.ewe)
                chk($sformatf("v%0d mem_wdata", idx), mem_wdata, t.dd);
        end
        if (t.eiv) chk($sformatf("v%0d if_rdata", idx), if_rdata, t.md);
        if (t.edv) chk($sformatf("v%0d dm_rdata", idx), dm_rdata, t.md);
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference state for the random run.
    int pend;
    bit mdrop;
    bit mbusy;
    int mcnt;
    int resp_in;

    initial begin
        int first;
        int cont;
        int exp_first;

        // Reset: outputs low even with requests and grant present.
        rst = 1'b1;
        drive_idle();
        if_req = 1; dm_req = 1; mem_gnt = 1;
        #12;
        chk("rst mem_req", mem_req, 0);
        chk("rst if_gnt", if_gnt, 0);
        chk("rst dm_gnt", dm_gnt, 0);
        chk("rst busy", busy, 0);
        chk("rst if_rvalid", if_rvalid, 0);
        chk("rst dm_rvalid", dm_rvalid, 0);
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b0;

        // ir ia ik dr dw da dd dm mg mv md | ig dg mr iv dv b addr mask we
        tbl.push_back(v(1,'h100,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h100,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,'h13,  0,0,0,1,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,'h104,0, 1,0,'h2000,0,'hf, 1,0,0, 0,1,1,0,0,0,'h2000,0,0));
        tbl.push_back(v(1,'h104,0, 0,0,0,0,0, 1,0,0,     0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(1,'h104,0, 0,0,0,0,0, 0,1,'h55,  0,0,0,0,1,1,0,0,0));
        tbl.push_back(v(1,'h104,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h104,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,'h77,  0,0,0,1,0,1,0,0,0));
        tbl.push_back(v(0,0,0, 1,1,'h3000,'hBEEF,'h3, 1,0,0, 0,1,1,0,0,0,'h3000,'h3,1));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,0,     0,0,0,0,1,1,0,0,0));
        tbl.push_back(v(1,'h108,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h108,0,0));
        tbl.push_back(v(0,0,1,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,'h99,  0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(1,'h10c,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h10c,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,'hAA,  0,0,0,1,0,1,0,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,0,0,     0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,'h110,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h110,0,0));
        tbl.push_back(v(0,0,1,     0,0,0,0,0, 0,1,'h1,   0,0,0,0,0,1,0,0,0));
        tbl.push_back(v(1,'h114,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h114,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,'hBB,  0,0,0,1,0,1,0,0,0));
        tbl.push_back(v(0,0,1,     0,0,0,0,0, 0,1,'h5,   0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,'h118,0, 0,0,0,0,0, 0,0,0,     0,0,1,0,0,0,'h118,0,0));
        tbl.push_back(v(1,'h118,0, 0,0,0,0,0, 1,0,0,     1,0,1,0,0,0,'h118,0,0));
        tbl.push_back(v(0,0,0,     0,0,0,0,0, 0,1,'hCC,  0,0,0,1,0,1,0,0,0));

        foreach (tbl[i]) apply_vec(tbl[i], i);
        drive_idle();

        // Reset in the middle of a data transaction.
        dm_req = 1; dm_addr = 'h4000; mem_gnt = 1;
        #4 chk("rstd grant", dm_gnt, 1);
        @(posedge clk);
        #1 mem_gnt = 0;
        #2 rst = 1'b1;
        #1;
        chk("rstd busy", busy, 0);
        chk("rstd mem_req", mem_req, 0);
        chk("rstd dm_gnt", dm_gnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dm_req = 0;
        mem_rvalid = 1; mem_rdata = 'h66;
        #4;
        chk("rstd late dm_rvalid", dm_rvalid, 0);
        chk("rstd late if_rvalid", if_rvalid, 0);
        chk("rstd late busy", busy, 0);
        @(posedge clk);
        #1 mem_rvalid = 0;
        #4 chk("rstd after busy", busy, 0);
        @(posedge clk);
        #1 dm_req = 1; mem_gnt = 1;
        #4 chk("rstd new grant", dm_gnt, 1);
        @(posedge clk);
        #1 dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 'h77;
        #4 chk("rstd new rvalid", dm_rvalid, 1);
        @(posedge clk);
        #1 drive_idle();

        // Continuous contention: ageing lets fetch in on the 3rd try.
        do_reset();
        first = 0;
        cont = 0;
        for (int k = 0; k < 12; k++) begin
            if_req = 1; if_addr = 'h200; dm_req = 1; dm_addr = 'h5000;
            mem_gnt = 1; mem_rvalid = (k % 2 == 1);
            #4;
            if (k % 2 == 0) begin
                cont++;
                if (if_gnt && first == 0) first = cont;
            end
            @(posedge clk);
            #1;
        end
`ifdef MEM_ARB_AGE_EN
        exp_first = MW + 1;
`else
        exp_first = 0;
`endif
        chk("age first fetch grant", first, exp_first);

        // Randomized run against the transaction-level model.
        do_reset();
        pend = 0; mdrop = 0; mbusy = 0; mcnt = 0; resp_in = 0;
        for (int n = 0; n < 2000; n++) begin
            bit urg, f_first, e_mr, e_ig, e_dg, e_iv, e_dv;
            if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hffff_fffc;
            end
            if (!dm_req && $urandom_range(2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(1));
                dm_addr = $urandom; dm_wdata = $urandom;
                dm_wmask = 4'($urandom);
            end
            mem_gnt = ($urandom_range(3) != 0);
            if_kill = ($urandom_range(7) == 0);
            mem_rdata = $urandom;
            if (pend != 0) begin
                resp_in--;
                mem_rvalid = (resp_in == 0);
            end else begin
                mem_rvalid = ($urandom_range(15) == 0);
            end
            #4;
`ifdef MEM_ARB_AGE_EN
            urg = (mcnt >= MW);
`else
            urg = 0;
`endif
            f_first = if_req && (!dm_req || urg);
            e_mr = (pend == 0) && (if_req || dm_req);
            e_ig = e_mr && f_first && mem_gnt;
            e_dg = e_mr && !f_first && mem_gnt;
            e_iv = (pend == 1) && mem_rvalid && !mdrop && !if_kill;
            e_dv = (pend == 2) && mem_rvalid;
            chk("rnd if_gnt", if_gnt, e_ig);
            chk("rnd dm_gnt", dm_gnt, e_dg);
            chk("rnd mem_req", mem_req, e_mr);
            chk("rnd if_rvalid", if_rvalid, e_iv);
            chk("rnd dm_rvalid", dm_rvalid, e_dv);
            chk("rnd busy", busy, mbusy);
            if (e_mr) begin
                chk("rnd mem_addr", mem_addr, f_first ? if_addr : dm_addr);
                chk("rnd mem_we", mem_we, !f_first && dm_we);
                chk("rnd mem_wmask", mem_wmask,
                    (!f_first && dm_we) ? {28'd0, dm_wmask} : 32'd0);
            end
            if (e_iv) chk("rnd if_rdata", if_rdata, mem_rdata);
            if (e_dv) chk("rnd dm_rdata", dm_rdata, mem_rdata);
            if (pend == 0) begin
                if (e_ig) mcnt = 0;
                else if (if_req && dm_req && !f_first && mcnt < 15) mcnt++;
                if (e_ig) begin
                    pend = 1; mdrop = if_kill; resp_in = $urandom_range(3, 1);
                end else if (e_dg) begin
                    pend = 2; resp_in = $urandom_range(3, 1);
                end
            end else if (mem_rvalid) begin
                pend = 0; mdrop = 0;
            end else if (pend == 1 && if_kill) begin
                mdrop = 1;
            end
            mbusy = (pend != 0);
            @(posedge clk);
            #1;
            if (e_ig) if_req = 0;
            if (e_dg) dm_req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for the core's single shared memory port. Arbitrates between instruction fetch and the data stage. Data-stage requests come from loads and stores decoded by the control unit, which raises `mem_read`/`mem_write`. The block allows one outstanding transaction, routes each response back to its owner, and supports dropping a fetch response that a taken branch or jump has made stale.

## Interface
Parameters:
- `AWIDTH`, 32: address width.
- `DWIDTH`, 32: data width; `DWIDTH/8` byte-enable bits.
- `MAX_WAIT`, 4: consecutive losses that make a fetch request urgent. Used only with `MEM_ARB_AGE_EN`; legal range is 1–15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held, with `if_addr`, until `if_gnt`.
- `if_addr` in AWIDTH: fetch address.
- `if_kill` in 1: the pending or outstanding fetch response is stale.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out DWIDTH: fetch data.
- `dm_req` in 1: data request (`mem_read | mem_write`). Held until `dm_gnt`.
- `dm_we` in 1: 1 = store.
- `dm_addr` in AWIDTH: data address.
- `dm_wdata` in DWIDTH: store data.
- `dm_wmask` in DWIDTH/8: store byte enables.
- `dm_gnt` out 1: data request accepted.
- `dm_rvalid` out 1: load data valid, or store acknowledge.
- `dm_rdata` out DWIDTH: load data.
- `mem_req` out 1: request to memory.
- `mem_we` out 1: write enable.
- `mem_addr` out AWIDTH: address.
- `mem_wdata` out DWIDTH: write data.
- `mem_wmask` out DWIDTH/8: byte enables. Forced to 0 for reads.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: response valid. Asserted once per accepted request, for both reads and writes.
- `mem_rdata` in DWIDTH: response data.
- `busy` out 1: a transaction is outstanding.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT_I: fetch transaction outstanding.
  - WAIT_D: data transaction outstanding.
- IDLE behaviour:
  - `mem_req = if_req | dm_req`.
  - The selected requester's fields drive `mem_*`.
  - If `mem_gnt` is high, the selected requester's `*_gnt` pulses and the state moves to WAIT_I or WAIT_D.
- Priority:
  - Data wins over fetch, because the data stage holds the older instruction.
  - Exception: with `MEM_ARB_AGE_EN`, an urgent fetch wins (see Configuration).
- WAIT_x behaviour:
  - `mem_req = 0`.
  - On `mem_rvalid`, the response is routed to the owner and the state returns to IDLE.
  - `if_rdata`/`dm_rdata` equal `mem_rdata` whenever the corresponding owner is selected; they are not registered.
- `if_kill` handling:
  - Sampled in WAIT_I, or in IDLE in the same cycle as a fetch grant: sets the register `drop`.
  - While `drop` is set, the next fetch response is consumed with `if_rvalid = 0`.
  - `drop` clears on that response.
  - `if_kill` with no fetch pending has no effect.
- A `mem_rvalid` received in IDLE is ignored.
- Reset state:
  - State IDLE; `drop` = 0; wait counter = 0.
  - All outputs 0: `mem_req`, `if_gnt`, `dm_gnt`, `if_rvalid`, `dm_rvalid`, `busy`.
- Reset asserted mid-transaction:
  - The outstanding transaction is abandoned.
  - Its late `mem_rvalid` arrives in IDLE and is ignored.

## Timing
- Issue occurs in the same cycle as request and `mem_gnt`; grant outputs are combinational.
- Responses pass through combinationally in the `mem_rvalid` cycle.
- The earliest next issue is the cycle after the response, because the FSM is back in IDLE. Peak throughput is therefore one transaction per two cycles.
- `busy` is registered: high from the cycle after a grant up to and including the response cycle.
- Simultaneous `if_req` and `dm_req`: one grant only, per the priority rule. The loser holds its request.
- `if_kill` in the same cycle as the fetch `mem_rvalid`: that response is suppressed, and `drop` is left clear afterwards.

## Configuration
- `MEM_ARB_AGE_EN` defined:
  - A 4-bit counter increments on each IDLE cycle in which `if_req` loses to `dm_req`.
  - It clears when `if_gnt` is granted.
  - When the count is ≥ `MAX_WAIT`, fetch wins the next contention.
- `MEM_ARB_AGE_EN` undefined: strict data priority; the counter is not built.

## Structure
- Shared package (`mem_arb_pkg`):
  - FSM state enum: IDLE, WAIT_I, WAIT_D.
  - Owner encoding.
- Optional sub-module `mem_arb_age`: the starvation counter plus the urgent flag, instantiated only under `MEM_ARB_AGE_EN`.
- Everything else lives in a single module.

## Test plan
- Lone fetch, `if_addr=0x100`, `mem_gnt=1`, response 2 cycles later with `0x13`:
  - `if_gnt` pulses in cycle 0; `if_rvalid=1`, `if_rdata=0x13` in cycle 2; `busy` high in cycles 1–2.
- `if_req` and `dm_req` (load, `0x2000`) raised together:
  - `dm_gnt` is granted first.
  - `if_gnt` comes in the cycle after `dm_rvalid`.
  - `mem_wmask=0` for the load.
- Store, `dm_wmask=0b0011`, `dm_wdata=0xBEEF`:
  - `mem_we=1`, mask and data pass through; `dm_rvalid` acks.
  - `if_rvalid` stays 0 throughout.
- `if_kill` in WAIT_I, response arrives 3 cycles later:
  - `if_rvalid` stays 0.
  - The next fetch's response is delivered normally.
- Reset pulse during WAIT_D:
  - Outputs return to 0 immediately.
  - A later `mem_rvalid` is ignored; a new request is granted normally.
- With `MEM_ARB_AGE_EN` and `MAX_WAIT=2`, continuous `dm_req` and `if_req`:
  - Fetch is granted on the 3rd contention.
  - Without the macro, fetch is never granted.
